// File: rtl/vga_sync_pattern_gen.sv
// VGA timing generator with registered pixel/sync outputs one clock behind Xpos/Ypos.
// Optional internal test patterns (bars, checker, gradient) enabled by macro VGA_PATTERN_EN.
module vga_sync_pattern_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned COLOR_W  = 8,
    parameter int unsigned POS_W    = 12,
    parameter int unsigned SYNC_POL = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         mode,
    input  logic [COLOR_W-1:0] R_i,
    input  logic [COLOR_W-1:0] G_i,
    input  logic [COLOR_W-1:0] B_i,
    output logic [POS_W-1:0]   Xpos,
    output logic [POS_W-1:0]   Ypos,
    output logic [COLOR_W-1:0] R_o,
    output logic [COLOR_W-1:0] G_o,
    output logic [COLOR_W-1:0] B_o,
    output logic               Hsync,
    output logic               Vsync,
    output logic               Hsync_neg,
    output logic               Vsync_neg,
    output logic               disp_activ,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CNT_W   = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             SYNC_ACT = (SYNC_POL != 0);

    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   vcnt_q, vcnt_d;
    logic [COLOR_W-1:0] r_q, g_q, b_q;
    logic [COLOR_W-1:0] pix_r, pix_g, pix_b;
    logic               hsync_q, vsync_q, disp_q, fs_q;
    logic               h_act, v_act, pix_act, h_sync_on, v_sync_on, frame_first;

    always_comb begin
        hcnt_d = hcnt_q + CNT_W'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_W'(1);
        end
    end

    assign h_act       = (hcnt_q < H_ACT);
    assign v_act       = (vcnt_q < V_ACT);
    assign pix_act     = h_act && v_act;
    assign h_sync_on   = (hcnt_q >= H_SS) && (hcnt_q <= H_SE);
    assign v_sync_on   = (vcnt_q >= V_SS) && (vcnt_q <= V_SE);
    assign frame_first = (hcnt_q == '0) && (vcnt_q == '0);

    assign Xpos = POS_W'(hcnt_q);
    assign Ypos = POS_W'(vcnt_q);

`ifdef VGA_PATTERN_EN
    localparam logic [CNT_W+2:0] BAR_DIV = (CNT_W + 3)'(H_ACTIVE);

    logic [3:0]       mode_q, mode_eff;
    logic [CNT_W+2:0] x8;
    logic [2:0]       bar;
    logic             chk;

    // The frame's first pixel already uses the mode being captured at that edge.
    assign mode_eff = frame_first ? mode : mode_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= '0;
        end else begin
            mode_q <= mode_eff;
        end
    end

    assign x8  = {hcnt_q, 3'b000};
    assign bar = 3'(x8 / BAR_DIV);
    assign chk = Xpos[3] ^ Ypos[3];

    always_comb begin
        pix_r = R_i;
        pix_g = G_i;
        pix_b = B_i;
        case (mode_eff)
            4'd1: begin
                pix_r = bar[2] ? '1 : '0;
                pix_g = bar[1] ? '1 : '0;
                pix_b = bar[0] ? '1 : '0;
            end
            4'd2: begin
                pix_r = chk ? '1 : '0;
                pix_g = chk ? '1 : '0;
                pix_b = chk ? '1 : '0;
            end
            4'd3: begin
                pix_r = COLOR_W'(Xpos);
                pix_g = COLOR_W'(Xpos);
                pix_b = COLOR_W'(Xpos);
            end
            default: ;
        endcase
    end
`else
    logic mode_unused;

    assign mode_unused = ^mode;
    assign pix_r       = R_i;
    assign pix_g       = G_i;
    assign pix_b       = B_i;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hsync_q <= ~SYNC_ACT;
            vsync_q <= ~SYNC_ACT;
            disp_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            r_q     <= pix_act ? pix_r : '0;
            g_q     <= pix_act ? pix_g : '0;
            b_q     <= pix_act ? pix_b : '0;
            hsync_q <= h_sync_on ? SYNC_ACT : ~SYNC_ACT;
            vsync_q <= v_sync_on ? SYNC_ACT : ~SYNC_ACT;
            disp_q  <= pix_act;
            fs_q    <= frame_first;
        end
    end

    assign R_o         = r_q;
    assign G_o         = g_q;
    assign B_o         = b_q;
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign Hsync_neg   = ~hsync_q;
    assign Vsync_neg   = ~vsync_q;
    assign disp_activ  = disp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_pattern_gen.sv
// Scoreboard bench for vga_sync_pattern_gen on a 16x8 timing (H 8/2/3/3, V 4/1/2/1).
// Expected outputs are queued per driven pixel and compared one clock later.
module tb_vga_sync_pattern_gen;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    typedef struct {
        logic [7:0] r, g, b;
        logic       hs, vs, da, fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  mode = 4'd0;
    logic [7:0]  R_i = 8'h00, G_i = 8'h00, B_i = 8'h00;
    logic [11:0] Xpos, Ypos;
    logic [7:0]  R_o, G_o, B_o;
    logic        Hsync, Vsync, Hsync_neg, Vsync_neg, disp_activ, frame_start;

    int   n_chk = 0, n_pass = 0;
    int   m_h = 0, m_v = 0;
    logic [3:0] m_mode = 4'd0;
    exp_t exp_q[$];
    int   cyc = 0, last_fs = 0, disp_cnt = 0;
    bit   fs_seen = 0;

    vga_sync_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .COLOR_W(8), .POS_W(12), .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .R_i(R_i), .G_i(G_i), .B_i(B_i),
        .Xpos(Xpos), .Ypos(Ypos),
        .R_o(R_o), .G_o(G_o), .B_o(B_o),
        .Hsync(Hsync), .Vsync(Vsync),
        .Hsync_neg(Hsync_neg), .Vsync_neg(Vsync_neg),
        .disp_activ(disp_activ), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d cyc=%0d)", tag, got, exp, m_h, m_v, cyc);
    endtask

    function automatic exp_t model(input int h, input int v, input logic [3:0] md,
                                   input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        bit   act;
        int   bar;
        logic c;
        act = (h < HA) && (v < VA);
        e.r = r; e.g = g; e.b = b;
`ifdef VGA_PATTERN_EN
        case (md)
            4'd1: begin
                bar = (h * 8) / HA;
                e.r = bar[2] ? 8'hFF : 8'h00;
                e.g = bar[1] ? 8'hFF : 8'h00;
                e.b = bar[0] ? 8'hFF : 8'h00;
            end
            4'd2: begin
                c = h[3] ^ v[3];
                e.r = c ? 8'hFF : 8'h00;
                e.g = e.r;
                e.b = e.r;
            end
            4'd3: begin
                e.r = h[7:0]; e.g = h[7:0]; e.b = h[7:0];
            end
            default: ;
        endcase
`else
        bar = 0;
        c   = md[0];
`endif
        if (!act) begin
            e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
        end
        e.hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
        e.vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
        e.da = act;
        e.fs = (h == 0) && (v == 0);
        return e;
    endfunction

    task automatic run_cycle(input logic [3:0] md, input bit rnd);
        exp_t       e;
        logic [3:0] eff;
        mode = md;
        if (rnd) begin
            R_i = 8'($urandom); G_i = 8'($urandom); B_i = 8'($urandom);
        end
        check_eq("xpos", 32'(Xpos), 32'(m_h));
        check_eq("ypos", 32'(Ypos), 32'(m_v));
        eff = (m_h == 0 && m_v == 0) ? md : m_mode;
        m_mode = eff;
        exp_q.push_back(model(m_h, m_v, eff, R_i, G_i, B_i));
        if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
            m_h++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        e = exp_q.pop_front();
        check_eq("R_o", 32'(R_o), 32'(e.r));
        check_eq("G_o", 32'(G_o), 32'(e.g));
        check_eq("B_o", 32'(B_o), 32'(e.b));
        check_eq("Hsync", 32'(Hsync), 32'(e.hs));
        check_eq("Vsync", 32'(Vsync), 32'(e.vs));
        check_eq("Hsync_neg", 32'(Hsync_neg), 32'(!e.hs));
        check_eq("Vsync_neg", 32'(Vsync_neg), 32'(!e.vs));
        check_eq("disp_activ", 32'(disp_activ), 32'(e.da));
        check_eq("frame_start", 32'(frame_start), 32'(e.fs));
        if (frame_start) begin
            if (fs_seen) begin
                check_eq("fs_period", 32'(cyc - last_fs), 32'(HT * VT));
                check_eq("disp_per_frame", 32'(disp_cnt), 32'(HA * VA));
            end
            fs_seen  = 1;
            last_fs  = cyc;
            disp_cnt = 0;
        end
        if (disp_activ) disp_cnt++;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_Xpos"}, 32'(Xpos), 32'd0);
        check_eq({tag, "_Ypos"}, 32'(Ypos), 32'd0);
        check_eq({tag, "_RGB"}, {8'h00, R_o, G_o, B_o}, 32'd0);
        check_eq({tag, "_disp"}, 32'(disp_activ), 32'd0);
        check_eq({tag, "_fs"}, 32'(frame_start), 32'd0);
        check_eq({tag, "_syncs"}, {28'd0, Hsync, Vsync, Hsync_neg, Vsync_neg}, 32'b1100);
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0; m_mode = 4'd0;
        exp_q.delete();
        fs_seen = 0; disp_cnt = 0;
    endtask

    initial begin
        // Power-on reset.
        rst = 1'b0;
        R_i = 8'hA5; G_i = 8'h3C; B_i = 8'h5A;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b1;
        model_reset();

        // Frame 1: constant passthrough pixel.
        for (int i = 0; i < HT * VT; i++) run_cycle(4'd0, 0);
        // Frame 2: mode switched to 2 at (3,1), must not take effect until next frame.
        for (int i = 0; i < HT * VT; i++)
            run_cycle((m_v > 1 || (m_v == 1 && m_h >= 3)) ? 4'd2 : 4'd0, 1);
        // Frame 3: checker; frames 4..6: bars, gradient, passthrough via unused mode code.
        for (int i = 0; i < HT * VT; i++) run_cycle(4'd2, 1);
        for (int i = 0; i < HT * VT; i++) run_cycle(4'd1, 1);
        for (int i = 0; i < HT * VT; i++) run_cycle(4'd3, 1);
        for (int i = 0; i < HT * VT; i++) run_cycle(4'd7, 1);

        // Mid-frame reset at (6,2).
        for (int i = 0; i < HT * VT && !(m_h == 6 && m_v == 2); i++) run_cycle(4'd1, 1);
        check_eq("reached_6_2", 32'(Xpos), 32'd6);
        rst = 1'b0;
        #1;
        check_reset_vals("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_vals("rst_hold");
        end
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < HT * VT + 20; i++) run_cycle(4'd2, 1);
        for (int i = 0; i < HT * VT; i++) run_cycle(4'd1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
